jtframe_dwnld_router: RTL and testbench
=======================================

// Module: jtframe_dwnld_router
// PURPOSE
//  Parametrised ROM-download router between the framework ioctl byte stream and the SDRAM
//  programming port plus on-chip PROM load strobes. Splits the download into up to REGIONS
//  regions, relocates each into SDRAM, packs bytes into 16-bit lanes with optional per-region
//  byte swap, and holds each write until the SDRAM side acknowledges it. Sits between
//  jtframe_mist and the game core, replacing ad-hoc per-game prog_* decoding.
// PARAMETERS
//  REGIONS    4                 number of download regions (1..8)
//  AW         22                ioctl/prog address width
//  START      {REGIONS{AW'd0}}  packed region start addresses in ioctl space, ascending; region 0 at 0
//  BASE       {REGIONS{AW'd0}}  packed SDRAM word base address per region
//  SWAB       {REGIONS{1'b0}}   per-region byte-lane swap
//  PROM_EN    1                 1: highest region targets PROMs, not SDRAM
// PORTS
//  clk          in   1      system clock; all logic on rising edge
//  rst          in   1      asynchronous, active-high reset
//  downloading  in   1      download window from framework
//  ioctl_addr   in   AW     byte address of incoming data
//  ioctl_data   in   8      byte data
//  ioctl_wr     in   1      one-cycle byte strobe
//  prog_addr    out  AW     SDRAM word address
//  prog_data    out  8      byte to write (replicated on both lanes by SDRAM side)
//  prog_mask    out  2      active-low lane enable: 2'b10 writes low byte, 2'b01 high byte
//  prog_we      out  1      write request, held high until prog_rdy
//  prog_rdy     in   1      SDRAM write acknowledge, one-cycle pulse
//  prom_addr    out  AW     byte offset inside PROM region
//  prom_data    out  8      PROM byte
//  prom_we      out  1      one-cycle PROM write strobe
//  region       out  3      region index of the last accepted byte
//  dwnld_done   out  1      one-cycle pulse once download has ended and the queue is empty
//  overrun      out  1      sticky: byte lost because the buffer was full
// BEHAVIOUR
//  - Reset: all outputs 0, prog_mask=2'b11, FSM=IDLE, buffer empty. overrun clears only on reset
//    or on a rising edge of downloading.
//  - Decode: region = highest i with ioctl_addr >= START[i]. off = ioctl_addr - START[i].
//    SDRAM: prog_addr = BASE[i] + off[AW-1:1]; lane = off[0]^SWAB[i]; lane 0 -> mask 2'b10.
//  - Decode and latch are registered: outputs change 1 cycle after ioctl_wr.
//  - ioctl_wr is ignored while downloading=0.
//  - PROM path (PROM_EN and i==REGIONS-1): prom_addr=off, prom_data=byte, prom_we high for
//    exactly 1 cycle, 1 cycle after ioctl_wr. The SDRAM FSM is not involved. No backpressure.
//  - SDRAM FSM:
//    - IDLE: a latched byte sets prog_we=1 -> WAIT.
//    - WAIT: prog_* stable. On prog_rdy, drop prog_we and set mask=2'b11.
//      - Buffer holds a byte: load it, raise prog_we on the next cycle, stay in WAIT.
//      - Buffer empty: go to IDLE.
//  - Buffer: one entry, filled by ioctl_wr while in WAIT.
//    - ioctl_wr with the buffer full: byte dropped, overrun=1.
//    - ioctl_wr in the same cycle as prog_rdy with the buffer full: the buffer drains first and
//      the new byte is accepted (no overrun).
//  - dwnld_done: armed on the falling edge of downloading. Pulses once, in the first cycle where
//    FSM=IDLE and the buffer is empty. A new rising edge before that cancels it.
//  - Address arithmetic wraps modulo 2^AW. A byte address below START[0] cannot occur (START[0]=0).
//  - Async reset mid-write drops prog_we immediately; the pending byte is lost and no done pulse
//    is produced.
// TESTING
//  - REGIONS=2, START={22'h8000,0}, BASE={22'h10000,0}. Write 0x5A @0x8003 -> prog_addr=0x10001,
//    mask=2'b01, data=0x5A; prog_we held until prog_rdy 5 cycles later.
//  - SWAB[0]=1: write @0x0000 -> mask=2'b01; write @0x0001 -> mask=2'b10; prog_addr=0 for both.
//  - PROM_EN=1, region 1 at 0x8000: write 0x3C @0x8010 -> prom_we 1 cycle, prom_addr=0x10,
//    prog_we stays 0.
//  - Three back-to-back ioctl_wr with prog_rdy delayed 10 cycles -> bytes 1 and 2 written in
//    order, byte 3 dropped, overrun=1 until the next rising edge of downloading.
//  - Drop downloading while one write is pending -> dwnld_done pulses exactly once, in the cycle
//    after that write's prog_rdy.
//  - Assert rst while prog_we=1 -> all outputs 0 same cycle; post-reset prog_rdy ignored,
//    no done pulse.

Source files
------------

// File: rtl/jtframe_dwnld_router.sv
// ROM-download router: splits the ioctl byte stream into regions, relocates bytes into
// 16-bit SDRAM words with a one-entry buffer behind the handshake, or strobes them into PROMs.
module jtframe_dwnld_router #(
    parameter int                      REGIONS = 4,
    parameter int                      AW      = 22,
    parameter logic [REGIONS*AW-1:0]   START   = '0,
    parameter logic [REGIONS*AW-1:0]   BASE    = '0,
    parameter logic [REGIONS-1:0]      SWAB    = '0,
    parameter int                      PROM_EN = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          downloading,
    input  logic [AW-1:0] ioctl_addr,
    input  logic [7:0]    ioctl_data,
    input  logic          ioctl_wr,
    output logic [AW-1:0] prog_addr,
    output logic [7:0]    prog_data,
    output logic [1:0]    prog_mask,
    output logic          prog_we,
    input  logic          prog_rdy,
    output logic [AW-1:0] prom_addr,
    output logic [7:0]    prom_data,
    output logic          prom_we,
    output logic [2:0]    region,
    output logic          dwnld_done,
    output logic          overrun
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    logic [AW-1:0] start_arr [REGIONS];
    logic [AW-1:0] base_arr  [REGIONS];

    generate
        for (genvar gi = 0; gi < REGIONS; gi++) begin : g_region
            assign start_arr[gi] = START[gi*AW +: AW];
            assign base_arr[gi]  = BASE[gi*AW +: AW];
        end
    endgenerate

    // Region decode: region 0 always starts at 0, so only higher regions need comparing
    logic [2:0]    dec_region;
    logic [AW-1:0] sel_start;
    logic [AW-1:0] sel_base;
    logic          sel_swab;
    logic [AW-1:0] dec_off;
    logic [AW-1:0] dec_addr;
    logic [1:0]    dec_mask;
    logic          dec_prom;

    always_comb begin
        dec_region = 3'd0;
        sel_start  = start_arr[0];
        sel_base   = base_arr[0];
        sel_swab   = SWAB[0];
        for (int i = 1; i < REGIONS; i++) begin
            if (ioctl_addr >= start_arr[i]) begin
                dec_region = 3'(i);
                sel_start  = start_arr[i];
                sel_base   = base_arr[i];
                sel_swab   = SWAB[i];
            end
        end
        dec_off  = ioctl_addr - sel_start;
        dec_addr = sel_base + {1'b0, dec_off[AW-1:1]};
        dec_mask = (dec_off[0] ^ sel_swab) ? 2'b01 : 2'b10;
        dec_prom = (PROM_EN != 0) && (dec_region == 3'(REGIONS-1));
    end

    logic [0:0]    state_reg,     state_next;
    logic [AW-1:0] prog_addr_reg, prog_addr_next;
    logic [7:0]    prog_data_reg, prog_data_next;
    logic [1:0]    prog_mask_reg, prog_mask_next;
    logic          prog_we_reg,   prog_we_next;
    logic [1:0]    pend_mask_reg, pend_mask_next;
    logic          buf_valid_reg, buf_valid_next;
    logic [AW-1:0] buf_addr_reg,  buf_addr_next;
    logic [7:0]    buf_data_reg,  buf_data_next;
    logic [1:0]    buf_mask_reg,  buf_mask_next;
    logic [AW-1:0] prom_addr_reg, prom_addr_next;
    logic [7:0]    prom_data_reg, prom_data_next;
    logic          prom_we_reg,   prom_we_next;
    logic [2:0]    region_reg,    region_next;
    logic          done_reg,      done_next;
    logic          armed_reg,     armed_next;
    logic          overrun_reg,   overrun_next;
    logic          dl_reg;

    logic accept;
    logic sdram_wr;

    assign accept   = downloading && ioctl_wr;
    assign sdram_wr = accept && !dec_prom;

    always_comb begin
        state_next     = state_reg;
        prog_addr_next = prog_addr_reg;
        prog_data_next = prog_data_reg;
        prog_mask_next = prog_mask_reg;
        prog_we_next   = prog_we_reg;
        pend_mask_next = pend_mask_reg;
        buf_valid_next = buf_valid_reg;
        buf_addr_next  = buf_addr_reg;
        buf_data_next  = buf_data_reg;
        buf_mask_next  = buf_mask_reg;
        prom_addr_next = prom_addr_reg;
        prom_data_next = prom_data_reg;
        prom_we_next   = 1'b0;
        region_next    = region_reg;
        done_next      = 1'b0;
        armed_next     = armed_reg;
        overrun_next   = overrun_reg;

        if (downloading && !dl_reg) begin
            overrun_next = 1'b0;
            armed_next   = 1'b0;
        end
        if (!downloading && dl_reg) begin
            armed_next = 1'b1;
        end

        if (accept) begin
            region_next = dec_region;
        end
        if (accept && dec_prom) begin
            prom_addr_next = dec_off;
            prom_data_next = ioctl_data;
            prom_we_next   = 1'b1;
        end

        case (state_reg)
            ST_IDLE: begin
                if (sdram_wr) begin
                    prog_addr_next = dec_addr;
                    prog_data_next = ioctl_data;
                    prog_mask_next = dec_mask;
                    prog_we_next   = 1'b1;
                    state_next     = ST_WAIT;
                end
            end
            default: begin
                if (prog_we_reg && prog_rdy) begin
                    prog_we_next   = 1'b0;
                    prog_mask_next = 2'b11;
                    // The buffer drains into the port first, so a byte arriving now finds room
                    if (buf_valid_reg) begin
                        prog_addr_next = buf_addr_reg;
                        prog_data_next = buf_data_reg;
                        pend_mask_next = buf_mask_reg;
                        buf_valid_next = sdram_wr;
                        if (sdram_wr) begin
                            buf_addr_next = dec_addr;
                            buf_data_next = ioctl_data;
                            buf_mask_next = dec_mask;
                        end
                    end else if (sdram_wr) begin
                        prog_addr_next = dec_addr;
                        prog_data_next = ioctl_data;
                        pend_mask_next = dec_mask;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else begin
                    if (!prog_we_reg) begin
                        prog_we_next   = 1'b1;
                        prog_mask_next = pend_mask_reg;
                    end
                    if (sdram_wr) begin
                        if (buf_valid_reg) begin
                            overrun_next = 1'b1;
                        end else begin
                            buf_valid_next = 1'b1;
                            buf_addr_next  = dec_addr;
                            buf_data_next  = ioctl_data;
                            buf_mask_next  = dec_mask;
                        end
                    end
                end
            end
        endcase

        if (armed_next && state_next == ST_IDLE && !buf_valid_next) begin
            done_next  = 1'b1;
            armed_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            prog_addr_reg <= '0;
            prog_data_reg <= '0;
            prog_mask_reg <= 2'b11;
            prog_we_reg   <= 1'b0;
            pend_mask_reg <= 2'b11;
            buf_valid_reg <= 1'b0;
            buf_addr_reg  <= '0;
            buf_data_reg  <= '0;
            buf_mask_reg  <= 2'b11;
            prom_addr_reg <= '0;
            prom_data_reg <= '0;
            prom_we_reg   <= 1'b0;
            region_reg    <= '0;
            done_reg      <= 1'b0;
            armed_reg     <= 1'b0;
            overrun_reg   <= 1'b0;
            dl_reg        <= 1'b0;
        end else begin
            state_reg     <= state_next;
            prog_addr_reg <= prog_addr_next;
            prog_data_reg <= prog_data_next;
            prog_mask_reg <= prog_mask_next;
            prog_we_reg   <= prog_we_next;
            pend_mask_reg <= pend_mask_next;
            buf_valid_reg <= buf_valid_next;
            buf_addr_reg  <= buf_addr_next;
            buf_data_reg  <= buf_data_next;
            buf_mask_reg  <= buf_mask_next;
            prom_addr_reg <= prom_addr_next;
            prom_data_reg <= prom_data_next;
            prom_we_reg   <= prom_we_next;
            region_reg    <= region_next;
            done_reg      <= done_next;
            armed_reg     <= armed_next;
            overrun_reg   <= overrun_next;
            dl_reg        <= downloading;
        end
    end

    assign prog_addr  = prog_addr_reg;
    assign prog_data  = prog_data_reg;
    assign prog_mask  = prog_mask_reg;
    assign prog_we    = prog_we_reg;
    assign prom_addr  = prom_addr_reg;
    assign prom_data  = prom_data_reg;
    assign prom_we    = prom_we_reg;
    assign region     = region_reg;
    assign dwnld_done = done_reg;
    assign overrun    = overrun_reg;

endmodule

// File: tb/tb_jtframe_dwnld_router.sv
// Bench for jtframe_dwnld_router: directed handshake/overrun/done/reset steps plus randomized
// region traffic checked against an arithmetic model of the region map.
module tb_jtframe_dwnld_router;

    localparam int REGIONS = 4;
    localparam int AW      = 22;
    localparam logic [REGIONS*AW-1:0] START = {22'h30000, 22'h10000, 22'h08000, 22'h00000};
    localparam logic [REGIONS*AW-1:0] BASE  = {22'h00000, 22'h3FF000, 22'h10000, 22'h00000};
    localparam logic [REGIONS-1:0]    SWAB  = 4'b0101;

    // Region map as plain numbers; region 3 is the PROM region
    int m_start [4] = '{32'h0, 32'h8000, 32'h10000, 32'h30000};
    int m_base  [4] = '{32'h0, 32'h10000, 32'h3FF000, 32'h0};
    int m_swab  [4] = '{1, 0, 1, 0};
    int m_size  [4] = '{32'h8000, 32'h8000, 32'h20000, 32'h3D0000};

    logic          clk = 1'b0;
    logic          rst;
    logic          downloading = 1'b0;
    logic [AW-1:0] ioctl_addr = '0;
    logic [7:0]    ioctl_data = '0;
    logic          ioctl_wr = 1'b0;
    logic [AW-1:0] prog_addr;
    logic [7:0]    prog_data;
    logic [1:0]    prog_mask;
    logic          prog_we;
    logic          prog_rdy = 1'b0;
    logic [AW-1:0] prom_addr;
    logic [7:0]    prom_data;
    logic          prom_we;
    logic [2:0]    region;
    logic          dwnld_done;
    logic          overrun;

    jtframe_dwnld_router #(
        .REGIONS (REGIONS),
        .AW      (AW),
        .START   (START),
        .BASE    (BASE),
        .SWAB    (SWAB),
        .PROM_EN (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .downloading (downloading),
        .ioctl_addr  (ioctl_addr),
        .ioctl_data  (ioctl_data),
        .ioctl_wr    (ioctl_wr),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .prog_mask   (prog_mask),
        .prog_we     (prog_we),
        .prog_rdy    (prog_rdy),
        .prom_addr   (prom_addr),
        .prom_data   (prom_data),
        .prom_we     (prom_we),
        .region      (region),
        .dwnld_done  (dwnld_done),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    always @(negedge clk) begin
        if (dwnld_done === 1'b1) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] exp_word(input int r, input int off);
        return AW'((m_base[r] + off / 2) % (1 << AW));
    endfunction

    function automatic logic [1:0] exp_mask(input int r, input int off);
        return (((off % 2) ^ m_swab[r]) != 0) ? 2'b01 : 2'b10;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_byte(input int a, input logic [7:0] d);
        ioctl_addr = AW'(a);
        ioctl_data = d;
        ioctl_wr   = 1'b1;
        tick();
        ioctl_wr   = 1'b0;
    endtask

    task automatic pulse_rdy();
        prog_rdy = 1'b1;
        tick();
        prog_rdy = 1'b0;
    endtask

    task automatic wait_we();
        for (int k = 0; k < 30 && prog_we !== 1'b1; k++) tick();
        check("we_timeout", 32'(prog_we), 32'd1);
    endtask

    // Expect one SDRAM write of byte d at region r offset off, ack it after dly cycles
    task automatic sdram_expect(input string tag, input int r, input int off,
                                input logic [7:0] d, input int dly);
        wait_we();
        check({tag, "_addr"}, 32'(prog_addr), 32'(exp_word(r, off)));
        check({tag, "_data"}, 32'(prog_data), 32'(d));
        check({tag, "_mask"}, 32'(prog_mask), 32'(exp_mask(r, off)));
        for (int k = 0; k < dly; k++) tick();
        check({tag, "_hold_we"}, 32'(prog_we), 32'd1);
        check({tag, "_hold_addr"}, 32'(prog_addr), 32'(exp_word(r, off)));
        pulse_rdy();
        check({tag, "_ack_we"}, 32'(prog_we), 32'd0);
        check({tag, "_ack_mask"}, 32'(prog_mask), 32'd3);
        $display("write %s region %0d off %0h data %0h", tag, r, off, d);
    endtask

    initial begin
        int c0;
        int extra;
        int r, off;
        logic [7:0] d;

        rst = 1'b1;
        repeat (2) tick();
        check("rst_we", 32'(prog_we), 32'd0);
        check("rst_mask", 32'(prog_mask), 32'd3);
        check("rst_addr", 32'(prog_addr), 32'd0);
        check("rst_prom_we", 32'(prom_we), 32'd0);
        check("rst_region", 32'(region), 32'd0);
        check("rst_done", 32'(dwnld_done), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        rst = 1'b0;
        tick();

        // Writes outside the download window are ignored
        wr_byte(32'h8003, 8'hEE);
        check("nodl_we", 32'(prog_we), 32'd0);
        check("nodl_prom", 32'(prom_we), 32'd0);
        repeat (3) tick();
        check("nodl_we_late", 32'(prog_we), 32'd0);

        downloading = 1'b1;
        repeat (2) tick();

        wr_byte(32'h8003, 8'h5A);
        check("reloc_region", 32'(region), 32'd1);
        check("reloc_abs_addr", 32'(prog_addr), 32'h10001);
        sdram_expect("reloc", 1, 3, 8'h5A, 5);

        wr_byte(32'h0000, 8'h11);
        sdram_expect("swab_even", 0, 0, 8'h11, 1);
        check("swab_even_abs", 32'(prog_mask), 32'd3);
        wr_byte(32'h0001, 8'h22);
        sdram_expect("swab_odd", 0, 1, 8'h22, 0);

        wr_byte(32'h30010, 8'h3C);
        check("prom_we", 32'(prom_we), 32'd1);
        check("prom_addr", 32'(prom_addr), 32'h10);
        check("prom_data", 32'(prom_data), 32'h3C);
        check("prom_region", 32'(region), 32'd3);
        check("prom_prog_we", 32'(prog_we), 32'd0);
        tick();
        check("prom_we_end", 32'(prom_we), 32'd0);
        check("prom_prog_we_late", 32'(prog_we), 32'd0);

        // Region 2 base lies near the top of the address space and wraps
        wr_byte(m_start[2] + 32'h1FFFF, 8'h77);
        sdram_expect("wrap", 2, 32'h1FFFF, 8'h77, 2);

        // Three back-to-back bytes with a slow acknowledge: third is lost
        wr_byte(m_start[1] + 32'h20, 8'hA1);
        wr_byte(m_start[1] + 32'h21, 8'hA2);
        wr_byte(m_start[1] + 32'h22, 8'hA3);
        check("ovr_set", 32'(overrun), 32'd1);
        sdram_expect("ovr_b1", 1, 32'h20, 8'hA1, 10);
        sdram_expect("ovr_b2", 1, 32'h21, 8'hA2, 0);
        extra = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (prog_we === 1'b1) extra++;
        end
        check("ovr_b3_dropped", 32'(extra), 32'd0);
        check("ovr_sticky", 32'(overrun), 32'd1);
        downloading = 1'b0;
        repeat (3) tick();
        check("ovr_sticky_fall", 32'(overrun), 32'd1);
        downloading = 1'b1;
        tick();
        check("ovr_clear_rise", 32'(overrun), 32'd0);

        // Byte arriving with the ack while the buffer is full is accepted
        wr_byte(m_start[1] + 32'h40, 8'hB1);
        wr_byte(m_start[1] + 32'h41, 8'hB2);
        tick();
        check("simul_b1_data", 32'(prog_data), 32'hB1);
        ioctl_addr = AW'(m_start[1] + 32'h42);
        ioctl_data = 8'hB3;
        ioctl_wr   = 1'b1;
        prog_rdy   = 1'b1;
        tick();
        ioctl_wr   = 1'b0;
        prog_rdy   = 1'b0;
        sdram_expect("simul_b2", 1, 32'h41, 8'hB2, 1);
        sdram_expect("simul_b3", 1, 32'h42, 8'hB3, 0);
        check("simul_no_ovr", 32'(overrun), 32'd0);

        // Done pulse right after the pending write completes
        wr_byte(m_start[1] + 32'h50, 8'hC1);
        wait_we();
        downloading = 1'b0;
        c0 = done_cnt;
        for (int k = 0; k < 4; k++) tick();
        check("done_early", 32'(dwnld_done), 32'd0);
        pulse_rdy();
        check("done_pulse", 32'(dwnld_done), 32'd1);
        repeat (5) tick();
        check("done_once", 32'(done_cnt - c0), 32'd1);
        $display("done pulse count %0d", done_cnt - c0);

        downloading = 1'b1;
        tick();
        for (int n = 0; n < 40; n++) begin
            r   = int'($urandom_range(0, 3));
            off = int'($urandom_range(0, m_size[r] - 1));
            d   = 8'($urandom);
            wr_byte(m_start[r] + off, d);
            check("rnd_region", 32'(region), 32'(r));
            if (r == 3) begin
                check("rnd_prom_we", 32'(prom_we), 32'd1);
                check("rnd_prom_addr", 32'(prom_addr), 32'(off));
                check("rnd_prom_data", 32'(prom_data), 32'(d));
                check("rnd_prom_prog", 32'(prog_we), 32'd0);
                tick();
                check("rnd_prom_end", 32'(prom_we), 32'd0);
                $display("prom region %0d off %0h data %0h", r, off, d);
            end else begin
                sdram_expect("rnd", r, off, d, int'($urandom_range(0, 4)));
            end
            repeat ($urandom_range(0, 2)) tick();
        end

        // Reset in the middle of a pending write
        wr_byte(m_start[1] + 32'h60, 8'hD1);
        wait_we();
        downloading = 1'b0;
        tick();
        c0 = done_cnt;
        #2 rst = 1'b1;
        #1;
        check("arst_we", 32'(prog_we), 32'd0);
        check("arst_addr", 32'(prog_addr), 32'd0);
        check("arst_data", 32'(prog_data), 32'd0);
        check("arst_mask", 32'(prog_mask), 32'd3);
        check("arst_region", 32'(region), 32'd0);
        tick();
        rst = 1'b0;
        pulse_rdy();
        extra = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (prog_we === 1'b1) extra++;
        end
        check("arst_no_we", 32'(extra), 32'd0);
        check("arst_no_done", 32'(done_cnt - c0), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
